// File: rtl/vram_dma.sv
// Byte-wide DMA from CPU space into VRAM, gated by vblank.
// Destinations outside the PMB/NTBL windows are walked over without a write strobe.
`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 12
`endif

// state   | meaning
// IDLE    | waiting for start
// READ    | issue source read (waits for vblank)
// CAPTURE | source data returns, latch into hold register
// WRITE   | write held byte to VRAM (waits for vblank if in range)
// FINISH  | one-cycle done pulse
module vram_dma #(
  parameter int                         VRAM_ADDR_WIDTH = `VRAM_ADDR_WIDTH,
  parameter logic [VRAM_ADDR_WIDTH-1:0] PMB_BASE        = VRAM_ADDR_WIDTH'(12'h200),
  parameter logic [VRAM_ADDR_WIDTH-1:0] NTBL_BASE       = VRAM_ADDR_WIDTH'(12'h400)
) (
  input  logic                       cpu_clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [15:0]                src_base,
  input  logic [VRAM_ADDR_WIDTH-1:0] dst_base,
  input  logic [10:0]                length,
  input  logic                       vblank,
  output logic [15:0]                src_addr,
  output logic                       src_rd,
  input  logic [7:0]                 src_data,
  output logic [VRAM_ADDR_WIDTH-1:0] vram_address,
  output logic [7:0]                 data_out,
  output logic                       write_enable,
  output logic                       SELECT_pmb,
  output logic                       SELECT_ntbl,
  output logic                       busy,
  output logic                       done
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_READ    = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_WRITE   = 3'd3;
  localparam logic [2:0] S_FINISH  = 3'd4;

  localparam int AW = VRAM_ADDR_WIDTH;

  logic [2:0]    state_q, state_d;
  logic [15:0]   src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [10:0]   cnt_q, cnt_d;
  logic [7:0]    data_q, data_d;

  // One extra bit so the window upper bounds cannot overflow the address width.
  logic [AW:0] addr_ext, pmb_lo, pmb_hi, ntbl_lo, ntbl_hi;
  logic        in_pmb, in_ntbl, in_range;

  assign addr_ext = {1'b0, dst_q};
  assign pmb_lo   = {1'b0, PMB_BASE};
  assign pmb_hi   = pmb_lo + (AW+1)'(512);
  assign ntbl_lo  = {1'b0, NTBL_BASE};
  assign ntbl_hi  = ntbl_lo + (AW+1)'(1024);
  assign in_pmb   = (addr_ext >= pmb_lo) && (addr_ext < pmb_hi);
  assign in_ntbl  = (addr_ext >= ntbl_lo) && (addr_ext < ntbl_hi);
  assign in_range = in_pmb || in_ntbl;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d   = src_base;
          dst_d   = dst_base;
          cnt_d   = length;
          state_d = (length == 11'd0) ? S_FINISH : S_READ;
        end
      end
      S_READ: begin
        if (vblank) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        data_d  = src_data;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        // Out-of-window bytes are consumed without waiting for vblank.
        if (vblank || !in_range) begin
          src_d   = src_q + 16'd1;
          dst_d   = dst_q + AW'(1);
          cnt_d   = cnt_q - 11'd1;
          state_d = (cnt_q == 11'd1) ? S_FINISH : S_READ;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  // Outputs are forced low while rst is asserted, before the reset edge lands.
  assign src_rd       = rst && (state_q == S_READ) && vblank;
  assign write_enable = rst && (state_q == S_WRITE) && vblank && in_range;
  assign SELECT_pmb   = write_enable && in_pmb;
  assign SELECT_ntbl  = write_enable && in_ntbl;
  assign busy         = rst && (state_q != S_IDLE);
  assign done         = rst && (state_q == S_FINISH);
  assign src_addr     = rst ? src_q : 16'd0;
  assign vram_address = rst ? dst_q : '0;
  assign data_out     = rst ? data_q : 8'd0;

endmodule

// File: tb/tb_vram_dma.sv
// Directed bench for vram_dma; source memory returns addr[7:0]^8'hA5 one cycle after src_rd.
`timescale 1ns/1ps
module tb_vram_dma;

  logic        clk = 1'b0;
  logic        rst, start, vblank, src_rd, write_enable;
  logic        SELECT_pmb, SELECT_ntbl, busy, done;
  logic [15:0] src_base, src_addr;
  logic [11:0] dst_base, vram_address;
  logic [10:0] length;
  logic [7:0]  src_data, data_out;

  int n_checks = 0;
  int n_errors = 0;

  logic [11:0] wa[$];
  logic [7:0]  wd[$];
  logic        wp[$], wn[$];
  int          wc[$];
  logic [15:0] ra[$];
  logic [7:0]  dq[$];
  int          n_rd, done_cyc, sel_bad, n_done;
  logic        busy_after, drop_we;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (src_rd) src_data <= src_addr[7:0] ^ 8'hA5;
  end

  vram_dma dut (
    .cpu_clk(clk), .rst(rst), .start(start), .src_base(src_base),
    .dst_base(dst_base), .length(length), .vblank(vblank),
    .src_addr(src_addr), .src_rd(src_rd), .src_data(src_data),
    .vram_address(vram_address), .data_out(data_out),
    .write_enable(write_enable), .SELECT_pmb(SELECT_pmb),
    .SELECT_ntbl(SELECT_ntbl), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_strobes"}, 32'({src_rd, write_enable, SELECT_pmb, SELECT_ntbl}), 32'd0);
    check({tag, "_src_addr"}, 32'(src_addr), 32'd0);
    check({tag, "_vram_address"}, 32'(vram_address), 32'd0);
    check({tag, "_data_out"}, 32'(data_out), 32'd0);
  endtask

  // Drop vblank for 5 cycles starting at drop_c; pulse a stray start at restart_c.
  task automatic run_xfer(input logic [15:0] s, input logic [11:0] d, input logic [10:0] l,
                          input int drop_c, input int restart_c);
    wa.delete(); wd.delete(); wp.delete(); wn.delete(); wc.delete(); ra.delete(); dq.delete();
    n_rd = 0; done_cyc = -1; sel_bad = 0; busy_after = 1'b1; drop_we = 1'b0;
    @(negedge clk);
    src_base = s; dst_base = d; length = l; start = 1'b1; vblank = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      start = (c == restart_c);
      if (start) begin
        src_base = 16'h4444; dst_base = 12'h450; length = 11'd3;
      end
      vblank = !(drop_c > 0 && c >= drop_c && c < drop_c + 5);
      #1;
      if (done_cyc > 0) begin
        busy_after = busy;
        break;
      end
      if (src_rd) begin n_rd++; ra.push_back(src_addr); end
      if (write_enable) begin
        wa.push_back(vram_address); wd.push_back(data_out);
        wp.push_back(SELECT_pmb); wn.push_back(SELECT_ntbl); wc.push_back(c);
      end
      if (!write_enable && (SELECT_pmb || SELECT_ntbl)) sel_bad++;
      if (!vblank) begin
        drop_we = drop_we | write_enable;
        dq.push_back(data_out);
      end
      if (done) done_cyc = c;
    end
    start = 1'b0;
    vblank = 1'b1;
    if (done_cyc < 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; vblank = 1'b0;
    src_base = '0; dst_base = '0; length = '0;
    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b1;

    // Basic PMB transfer with a stray start mid-transfer.
    run_xfer(16'h8000, 12'h200, 11'd4, 0, 5);
    check("t1_nwrites", 32'(wa.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("t1_addr", 32'(wa[i]), 32'h200 + 32'(i));
      check("t1_data", 32'(wd[i]), 32'(8'(i) ^ 8'hA5));
      check("t1_sel_pmb", 32'(wp[i]), 32'd1);
      check("t1_sel_ntbl", 32'(wn[i]), 32'd0);
    end
    check("t1_done_cycle", 32'(done_cyc), 32'd13);
    check("t1_busy_after", 32'(busy_after), 32'd0);
    check("t1_nreads", 32'(n_rd), 32'd4);
    check("t1_sel_idle", 32'(sel_bad), 32'd0);

    // Zero-length transfer.
    run_xfer(16'h1000, 12'h200, 11'd0, 0, 0);
    check("t2_nreads", 32'(n_rd), 32'd0);
    check("t2_nwrites", 32'(wa.size()), 32'd0);
    check("t2_done_cycle", 32'(done_cyc), 32'd1);
    check("t2_busy_after", 32'(busy_after), 32'd0);

    // vblank dropped during the first WRITE (cycles 3..7).
    run_xfer(16'h8000, 12'h200, 11'd4, 3, 0);
    check("t3_drop_we", 32'(drop_we), 32'd0);
    check("t3_drop_len", 32'(dq.size()), 32'd5);
    foreach (dq[i]) check("t3_drop_hold", 32'(dq[i]), 32'hA5);
    check("t3_first_write_cycle", 32'(wc[0]), 32'd8);
    check("t3_first_data", 32'(wd[0]), 32'hA5);
    check("t3_nwrites", 32'(wa.size()), 32'd4);
    check("t3_last_addr", 32'(wa[3]), 32'h203);
    check("t3_done_cycle", 32'(done_cyc), 32'd18);

    // Start below PMB: first two bytes skipped.
    run_xfer(16'h1234, 12'h1FE, 11'd4, 0, 0);
    check("t4_nwrites", 32'(wa.size()), 32'd2);
    check("t4_addr0", 32'(wa[0]), 32'h200);
    check("t4_addr1", 32'(wa[1]), 32'h201);
    check("t4_data0", 32'(wd[0]), 32'h93);
    check("t4_data1", 32'(wd[1]), 32'h92);
    check("t4_pmb", 32'({wp[0], wp[1]}), 32'h3);
    check("t4_done_cycle", 32'(done_cyc), 32'd13);
    check("t4_nreads", 32'(n_rd), 32'd4);

    // Last NTBL byte, then out of range; source wraps.
    run_xfer(16'hFFFF, 12'h7FF, 11'd2, 0, 0);
    check("t5_nwrites", 32'(wa.size()), 32'd1);
    check("t5_addr", 32'(wa[0]), 32'h7FF);
    check("t5_data", 32'(wd[0]), 32'h5A);
    check("t5_ntbl", 32'(wn[0]), 32'd1);
    check("t5_pmb", 32'(wp[0]), 32'd0);
    check("t5_src_wrap", 32'(ra[1]), 32'h0000);
    check("t5_done_cycle", 32'(done_cyc), 32'd7);

    // Reset during the second byte of a 10-byte transfer.
    @(negedge clk);
    src_base = 16'h3000; dst_base = 12'h400; length = 11'd10; start = 1'b1; vblank = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 5) rst = 1'b0;
    end
    #1;
    check_idle_outputs("in_reset");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_idle_outputs("post_reset");
    n_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (done || busy) n_done++;
    end
    check("t6_no_resume", 32'(n_done), 32'd0);
    run_xfer(16'h0010, 12'h410, 11'd1, 0, 0);
    check("t6_nwrites", 32'(wa.size()), 32'd1);
    check("t6_addr", 32'(wa[0]), 32'h410);
    check("t6_data", 32'(wd[0]), 32'hB5);
    check("t6_ntbl", 32'(wn[0]), 32'd1);
    check("t6_done_cycle", 32'(done_cyc), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
